serial_adder_ctrl: RTL and testbench

Bit-serial adder controller. It sequences a single 1-bit full-adder cell over WIDTH clock cycles to add two WIDTH-bit operands plus a carry-in, and returns a WIDTH-bit sum and carry-out with a start/busy/done handshake. It sits next to the full-adder cells as the area-minimal alternative to a ripple-carry chain, and it is the first sequential block in the adder library.

---
 rtl/adder_pkg.sv | 16 +
 rtl/fa_cell.sv | 13 +
 rtl/serial_adder_ctrl.sv | 101 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder library: controller state encoding and default width.
package adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRun  = RUN,
    StDone = DONE
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: steps one full-adder cell over WIDTH cycles, LSB first,
// with a start/busy/done handshake.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sa_q, sa_d;
  logic [WIDTH-1:0]  sb_q, sb_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              fa_sum, fa_cout;

  fa_cell u_fa_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        // Shift form stays legal when WIDTH is 1.
        sum_d   = (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        carry_d = fa_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          // cout is a separate flop so it holds across the next RUN.
          cout_d  = fa_cout;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed handshake scenarios plus a randomized
// sweep against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in cycle 1 after an accepted start; returns in the done cycle.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      check("busy_run", busy, 1);
      step();
      lat++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       input string tag);
    logic [W:0] exp;
    int lat;
    exp   = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    step();
    start = 1'b0;
    // Scramble operands after capture; the result must not change.
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    wait_done(lat);
    check({tag, "_lat"}, lat, W + 1);
    check({tag, "_sum"}, sum, exp[W-1:0]);
    check({tag, "_cout"}, cout, exp[W]);
    check({tag, "_busy_at_done"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    step();

    issue(8'h0F, 8'h01, 1'b0, "basic");
    step();
    issue(8'hFF, 8'h01, 1'b0, "ovf1");
    step();
    issue(8'hFF, 8'hFF, 1'b1, "ovf2");
    step();

    // Start during RUN must be ignored.
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    step();
    seen = 0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 3) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen++;
        if (seen == 1) begin
          check("prot_lat", c, 9);
          check("prot_sum", sum, 8'h46);
          check("prot_cout", cout, 0);
        end
      end
      step();
    end
    start = 1'b0;
    check("prot_single_done", seen, 1);

    // issue() returns in the done cycle, so chained calls are back-to-back.
    issue(8'h33, 8'h44, 1'b1, "b2b1");
    issue(8'h80, 8'h80, 1'b0, "b2b2");
    step();
    issue(8'hF0, 8'hF0, 1'b0, "pre_rst");
    step();

    // Reset in cycle 4 of an add.
    a     = 8'h55;
    b     = 8'h22;
    cin   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) seen++;
      step();
    end
    check("abort_no_done", seen, 0);
    issue(8'h01, 8'h01, 1'b0, "post_rst");

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) step();
      issue(W'($urandom), W'($urandom), 1'($urandom), "rand");
    end
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
